// File: rtl/db15_pkg.sv
// db15_pkg: shared definitions for the DB15 serial joystick link.
//   - frame length and responder FSM state type
//   - button bit positions within a 16-bit joystick word (shared with the receiver)
//   - db15_frame(): packs two joystick words into the on-wire frame order
package db15_pkg;

    localparam int DB15_FRAME_BITS = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } db15_state_t;

    // Button positions inside a joystick word (1 = pressed).
    localparam int BTN_R      = 0;
    localparam int BTN_L      = 1;
    localparam int BTN_X      = 2;
    localparam int BTN_A      = 3;
    localparam int BTN_RIGHT  = 4;
    localparam int BTN_LEFT   = 5;
    localparam int BTN_DOWN   = 6;
    localparam int BTN_UP     = 7;
    localparam int BTN_START  = 8;
    localparam int BTN_SELECT = 9;
    localparam int BTN_Y      = 10;
    localparam int BTN_B      = 11;
    localparam int BTN_C      = 12;
    localparam int BTN_Z      = 13;
    localparam int BTN_MODE   = 14;
    localparam int BTN_HOME   = 15;

    // Player 1 goes out first, so it sits in the low half (bit0 leaves first).
    function automatic logic [DB15_FRAME_BITS-1:0] db15_frame(input logic [15:0] j1,
                                                              input logic [15:0] j2);
        return {j2, j1};
    endfunction

endpackage

// File: rtl/sync_edge.sv
// sync_edge: multi-flop synchronizer with rise/fall detection.
//   clk, reset : system clock, synchronous active-high reset
//   in         : asynchronous input pin
//   out_sync   : synchronized level (STAGES flops after the pin)
//   rise, fall : one-cycle pulses derived from the last two synchronized samples
// RST_VAL is the idle level of the pin, so leaving reset never fakes an edge.
module sync_edge
    import db15_pkg::*;
#(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic in,
    output logic out_sync,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain;
    logic              prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            chain <= {STAGES{RST_VAL}};
            prev  <= RST_VAL;
        end else begin
            chain <= {chain[STAGES-2:0], in};
            prev  <= chain[STAGES-1];
        end
    end

    assign out_sync = chain[STAGES-1];
    assign rise     = out_sync & ~prev;
    assign fall     = ~out_sync & prev;

endmodule

// File: rtl/joy_db15_responder.sv
// joy_db15_responder: device end of the DB15 serial joystick link.
// Behaves like a parallel-in/serial-out shift chain: while the host holds
// joy_load low the two joystick words are captured continuously, and after
// load is released each host joy_clk rising edge shifts the next bit out.
//   clk        : system clock (>= 8x host joy_clk)
//   reset      : synchronous, active-high
//   joystick1/2: button maps, 1 = pressed
//   joy_clk    : host shift clock (async)
//   joy_load   : host load strobe (async, active-low)
//   joy_data   : registered serial data to host
//   busy       : frame partly shifted out
//   frame_done : one-cycle pulse when the last frame bit is presented
//   bit_index  : index of the bit currently on joy_data
module joy_db15_responder
    import db15_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FRAME_BITS  = DB15_FRAME_BITS,
    parameter bit ACTIVE_LOW  = 1'b1,
    parameter bit FILL_BIT    = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] joystick1,
    input  logic [15:0] joystick2,
    input  logic        joy_clk,
    input  logic        joy_load,
    output logic        joy_data,
    output logic        busy,
    output logic        frame_done,
    output logic [4:0]  bit_index
);

    localparam logic [4:0] LAST_IDX = 5'(FRAME_BITS - 1);
    // Level that means "nothing pressed" on the wire.
    localparam logic       IDLE_LVL = ACTIVE_LOW;

    logic ck_sync, ck_rise, ck_fall;
    logic ld_sync, ld_rise, ld_fall;

    sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_clk (
        .clk      (clk),
        .reset    (reset),
        .in       (joy_clk),
        .out_sync (ck_sync),
        .rise     (ck_rise),
        .fall     (ck_fall)
    );

    sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_load (
        .clk      (clk),
        .reset    (reset),
        .in       (joy_load),
        .out_sync (ld_sync),
        .rise     (ld_rise),
        .fall     (ld_fall)
    );

    // Load acts on the synchronized level, and joy_clk falling edges mean
    // nothing, so these detector outputs are intentionally left unused.
    logic unused_edges;
    assign unused_edges = ^{ck_sync, ck_fall, ld_rise, ld_fall};

    db15_state_t             state, state_nxt;
    logic [FRAME_BITS-1:0]   sr, sr_nxt;
    logic [FRAME_BITS-1:0]   capture;
    logic [4:0]              idx_nxt;
    logic                    jd_nxt, busy_nxt, done_nxt;

    assign capture = FRAME_BITS'(db15_frame(joystick1, joystick2));

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            sr         <= {FRAME_BITS{FILL_BIT}};
            bit_index  <= '0;
            joy_data   <= IDLE_LVL;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            sr         <= sr_nxt;
            bit_index  <= idx_nxt;
            joy_data   <= jd_nxt;
            busy       <= busy_nxt;
            frame_done <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        sr_nxt    = sr;
        idx_nxt   = bit_index;
        jd_nxt    = joy_data;
        busy_nxt  = busy;
        done_nxt  = 1'b0;

        if (!ld_sync) begin
            // Load low wins from every state, including over a clock edge in
            // the same cycle; a partial frame is simply abandoned. joy_data is
            // transparent to joystick1[0] like a '165 with its load asserted.
            state_nxt = LOAD;
            sr_nxt    = capture;
            idx_nxt   = '0;
            jd_nxt    = joystick1[0] ^ ACTIVE_LOW;
            busy_nxt  = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    jd_nxt = IDLE_LVL;
                end
                LOAD: begin
                    // Load just released: freeze the last capture. Any clock
                    // edge seen this cycle is dropped.
                    state_nxt = SHIFT;
                    jd_nxt    = sr[0] ^ ACTIVE_LOW;
                end
                SHIFT: begin
                    if (ck_rise) begin
                        sr_nxt  = {FILL_BIT, sr[FRAME_BITS-1:1]};
                        idx_nxt = bit_index + 5'd1;
                        jd_nxt  = sr[1] ^ ACTIVE_LOW;
                        if (bit_index == LAST_IDX - 5'd1) begin
                            done_nxt  = 1'b1;
                            busy_nxt  = 1'b0;
                            state_nxt = DONE;
                        end else begin
                            busy_nxt = 1'b1;
                        end
                    end
                end
                DONE: begin
                    // Last bit stays up until the host clocks past it; after
                    // that the line idles and the index stays saturated.
                    if (ck_rise) begin
                        sr_nxt = {FILL_BIT, sr[FRAME_BITS-1:1]};
                        jd_nxt = IDLE_LVL;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

endmodule
